// File: rtl/fifo_word_packer_if.sv
// Bundles the FIFO show-ahead read port and the packed-word valid/ready stream
// that fifo_word_packer sits between.
interface fifo_word_packer_if #(
  parameter int DATA_WIDTH = 8,
  parameter int LANES      = 2
);
  logic                        r_empty;
  logic [DATA_WIDTH-1:0]       r_data;
  logic                        r_inc;
  logic                        o_valid;
  logic                        o_ready;
  logic [DATA_WIDTH*LANES-1:0] o_data;
  logic [LANES-1:0]            o_keep;

  modport master (
    input  r_empty,
    input  r_data,
    input  o_ready,
    output r_inc,
    output o_valid,
    output o_data,
    output o_keep
  );

  modport slave (
    output r_empty,
    output r_data,
    output o_ready,
    input  r_inc,
    input  o_valid,
    input  o_data,
    input  o_keep
  );
endinterface

// File: rtl/fifo_word_packer.sv
// Drains a show-ahead FIFO and packs LANES consecutive entries into one registered word.
// Define FIFO_WORD_PACKER_FLUSH_EN to flush partial words after PACK_TIMEOUT idle cycles.
module fifo_word_packer #(
  parameter int DATA_WIDTH   = 8,
  parameter int LANES        = 2,
  parameter int PACK_TIMEOUT = 16
) (
  input  logic               clk,
  input  logic               reset,
  fifo_word_packer_if.master bus
);
  localparam int LW = $clog2(LANES);
  localparam int AW = (LANES - 1) * DATA_WIDTH;
  localparam int OW = LANES * DATA_WIDTH;

  if (LANES < 2 || PACK_TIMEOUT < 1) begin : g_cfg_check
    $error("fifo_word_packer: LANES must be >= 2 and PACK_TIMEOUT >= 1");
  end

  logic [LW-1:0]    r_lane_cnt;
  logic [AW-1:0]    r_acc;
  logic [OW-1:0]    r_out_data;
  logic [LANES-1:0] r_out_keep;
  logic             r_out_valid;

  logic w_out_free;
  logic w_last_lane;
  logic w_pop;

  assign w_out_free  = !r_out_valid || bus.o_ready;
  assign w_last_lane = (r_lane_cnt == LW'(LANES - 1));
  // The last lane may only be popped when the output register can take the word.
  assign w_pop       = !reset && !bus.r_empty && (!w_last_lane || w_out_free);

  assign bus.r_inc   = w_pop;
  assign bus.o_valid = r_out_valid;
  assign bus.o_data  = r_out_data;
  assign bus.o_keep  = r_out_keep;

`ifdef FIFO_WORD_PACKER_FLUSH_EN
  localparam int TW = $clog2(PACK_TIMEOUT + 1);

  logic [TW-1:0]    r_idle_cnt;
  logic             w_timeout;
  logic             w_flush;
  logic [OW-1:0]    w_flush_data;
  logic [LANES-1:0] w_flush_keep;

  assign w_timeout = (r_idle_cnt == TW'(PACK_TIMEOUT));
  assign w_flush   = w_timeout && (r_lane_cnt != '0) && w_out_free && !w_pop;

  // Idle counter: saturates at the timeout, cleared by any pop or flush.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_idle_cnt <= '0;
    end else if (w_pop || w_flush) begin
      r_idle_cnt <= '0;
    end else if ((r_lane_cnt != '0) && !w_timeout) begin
      r_idle_cnt <= r_idle_cnt + TW'(1);
    end
  end

  // Partial word: filled lanes copied from the accumulator, the rest zero.
  always_comb begin
    w_flush_data = '0;
    w_flush_keep = '0;
    for (int i = 0; i < LANES - 1; i++) begin
      if (i < int'(r_lane_cnt)) begin
        w_flush_data[i*DATA_WIDTH +: DATA_WIDTH] = r_acc[i*DATA_WIDTH +: DATA_WIDTH];
        w_flush_keep[i]                          = 1'b1;
      end else begin
        w_flush_data[i*DATA_WIDTH +: DATA_WIDTH] = '0;
        w_flush_keep[i]                          = 1'b0;
      end
    end
  end
`endif

  // Lane counter: advances per pop, wraps after the last lane.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_lane_cnt <= '0;
    end else if (w_pop) begin
      r_lane_cnt <= w_last_lane ? '0 : r_lane_cnt + LW'(1);
`ifdef FIFO_WORD_PACKER_FLUSH_EN
    end else if (w_flush) begin
      r_lane_cnt <= '0;
`endif
    end
  end

  // Accumulator keeps filling even while an output word is stalled.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_acc <= '0;
    end else if (w_pop && !w_last_lane) begin
      r_acc[r_lane_cnt*DATA_WIDTH +: DATA_WIDTH] <= bus.r_data;
    end
  end

  // Output register: load completes a word, acceptance without load retires it.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_out_data  <= '0;
      r_out_keep  <= '0;
      r_out_valid <= 1'b0;
    end else if (w_pop && w_last_lane) begin
      r_out_data  <= {bus.r_data, r_acc};
      r_out_keep  <= '1;
      r_out_valid <= 1'b1;
`ifdef FIFO_WORD_PACKER_FLUSH_EN
    end else if (w_flush) begin
      r_out_data  <= w_flush_data;
      r_out_keep  <= w_flush_keep;
      r_out_valid <= 1'b1;
`endif
    end else if (r_out_valid && bus.o_ready) begin
      r_out_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_fifo_word_packer.sv
// Directed bench for fifo_word_packer (DATA_WIDTH=8, LANES=2) with a FIFO model and word scoreboard.
module tb_fifo_word_packer;
`ifdef FIFO_WORD_PACKER_FLUSH_EN
  localparam int PT  = 4;
  localparam int GAP = PT - 1;
`else
  localparam int PT  = 16;
  localparam int GAP = 5;
`endif

  logic clk = 1'b0;
  logic rst;
  logic inc;
  int   checks = 0;
  int   errors = 0;

  logic [7:0]  fifo_q[$];
  logic [31:0] sb_q[$];

  fifo_word_packer_if #(.DATA_WIDTH(8), .LANES(2)) bus ();

  fifo_word_packer #(.DATA_WIDTH(8), .LANES(2), .PACK_TIMEOUT(PT)) dut (
    .clk   (clk),
    .reset (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs mid-cycle, score any accepted word, then advance the FIFO model.
  task automatic step(input logic rst_i, input logic rdy, output logic inc_o);
    logic [31:0] exp_word;
    @(negedge clk);
    rst         = rst_i;
    bus.o_ready = rdy;
    bus.r_empty = (fifo_q.size() == 0);
    bus.r_data  = (fifo_q.size() != 0) ? fifo_q[0] : 8'h00;
    #1;
    inc_o = bus.r_inc;
    check("inc_vs_empty", {31'd0, inc_o & bus.r_empty}, 32'd0);
    if (bus.o_valid && bus.o_ready) begin
      if (sb_q.size() != 0) exp_word = sb_q.pop_front();
      else exp_word = 32'hDEAD_BEEF;
      check("word", {14'd0, bus.o_keep, bus.o_data}, exp_word);
    end
    @(posedge clk);
    if (inc_o) fifo_q.delete(0);
    #1;
  endtask

  task automatic expect_word(input string tag, input logic [15:0] data, input logic [1:0] keep);
    check({tag, "_valid"}, {31'd0, bus.o_valid}, 32'd1);
    check({tag, "_data"}, {16'd0, bus.o_data}, {16'd0, data});
    check({tag, "_keep"}, {30'd0, bus.o_keep}, {30'd0, keep});
  endtask

  initial begin
    rst         = 1'b1;
    bus.r_empty = 1'b1;
    bus.r_data  = 8'h00;
    bus.o_ready = 1'b0;

    // Reset held with a non-empty FIFO: nothing popped, outputs cleared.
    fifo_q.push_back(8'h99);
    repeat (3) begin
      step(1'b1, 1'b1, inc);
      check("rst_inc", {31'd0, inc}, 32'd0);
    end
    check("rst_valid", {31'd0, bus.o_valid}, 32'd0);
    check("rst_data", {16'd0, bus.o_data}, 32'd0);
    check("rst_keep", {30'd0, bus.o_keep}, 32'd0);
    fifo_q.delete();

    // Streaming at full rate.
    fifo_q.push_back(8'h2A); fifo_q.push_back(8'h2B);
    fifo_q.push_back(8'h2C); fifo_q.push_back(8'h2D);
    sb_q.push_back(32'h0003_2B2A); sb_q.push_back(32'h0003_2D2C);
    step(1'b0, 1'b1, inc); check("str_inc0", {31'd0, inc}, 32'd1);
    check("str_lat", {31'd0, bus.o_valid}, 32'd0);
    step(1'b0, 1'b1, inc); check("str_inc1", {31'd0, inc}, 32'd1);
    expect_word("str_w0", 16'h2B2A, 2'b11);
    step(1'b0, 1'b1, inc); check("str_inc2", {31'd0, inc}, 32'd1);
    check("str_retire", {31'd0, bus.o_valid}, 32'd0);
    step(1'b0, 1'b1, inc); check("str_inc3", {31'd0, inc}, 32'd1);
    expect_word("str_w1", 16'h2D2C, 2'b11);
    step(1'b0, 1'b1, inc); check("str_drain", {31'd0, inc}, 32'd0);
    check("str_idle", {31'd0, bus.o_valid}, 32'd0);

    // Backpressure: first word held, one more entry buffered, then stall.
    fifo_q.push_back(8'h01); fifo_q.push_back(8'h02);
    fifo_q.push_back(8'h03); fifo_q.push_back(8'h04);
    sb_q.push_back(32'h0003_0201); sb_q.push_back(32'h0003_0403);
    step(1'b0, 1'b0, inc); check("bp_inc0", {31'd0, inc}, 32'd1);
    step(1'b0, 1'b0, inc); check("bp_inc1", {31'd0, inc}, 32'd1);
    expect_word("bp_w0", 16'h0201, 2'b11);
    step(1'b0, 1'b0, inc); check("bp_inc2", {31'd0, inc}, 32'd1);
    expect_word("bp_hold0", 16'h0201, 2'b11);
    repeat (2) begin
      step(1'b0, 1'b0, inc); check("bp_stall", {31'd0, inc}, 32'd0);
      expect_word("bp_hold", 16'h0201, 2'b11);
    end
    step(1'b0, 1'b1, inc); check("bp_resume", {31'd0, inc}, 32'd1);
    expect_word("bp_w1", 16'h0403, 2'b11);
    step(1'b0, 1'b1, inc); check("bp_drain", {31'd0, inc}, 32'd0);
    check("bp_idle", {31'd0, bus.o_valid}, 32'd0);

    // Empty gap mid-word: no partial output.
    fifo_q.push_back(8'h10);
    sb_q.push_back(32'h0003_2010);
    step(1'b0, 1'b1, inc); check("gap_inc0", {31'd0, inc}, 32'd1);
    repeat (GAP) begin
      step(1'b0, 1'b1, inc);
      check("gap_quiet", {31'd0, bus.o_valid}, 32'd0);
    end
    fifo_q.push_back(8'h20);
    step(1'b0, 1'b1, inc); check("gap_inc1", {31'd0, inc}, 32'd1);
    expect_word("gap_w", 16'h2010, 2'b11);
    step(1'b0, 1'b1, inc);
    check("gap_idle", {31'd0, bus.o_valid}, 32'd0);

    // Reset mid-word discards the partial accumulator.
    fifo_q.push_back(8'h55);
    step(1'b0, 1'b1, inc); check("mr_inc55", {31'd0, inc}, 32'd1);
    fifo_q.push_back(8'h66); fifo_q.push_back(8'h77);
    step(1'b1, 1'b1, inc); check("mr_rst_inc", {31'd0, inc}, 32'd0);
    check("mr_rst_valid", {31'd0, bus.o_valid}, 32'd0);
    sb_q.push_back(32'h0003_7766);
    step(1'b0, 1'b1, inc); check("mr_inc66", {31'd0, inc}, 32'd1);
    step(1'b0, 1'b1, inc); check("mr_inc77", {31'd0, inc}, 32'd1);
    expect_word("mr_w", 16'h7766, 2'b11);
    step(1'b0, 1'b1, inc);

    // Lone entry followed by a long empty period.
    fifo_q.push_back(8'hAB);
    step(1'b0, 1'b1, inc); check("fl_inc", {31'd0, inc}, 32'd1);
`ifdef FIFO_WORD_PACKER_FLUSH_EN
    sb_q.push_back(32'h0001_00AB);
    repeat (PT) begin
      step(1'b0, 1'b1, inc);
      check("fl_wait", {31'd0, bus.o_valid}, 32'd0);
    end
    step(1'b0, 1'b1, inc);
    expect_word("fl_w", 16'h00AB, 2'b01);
    step(1'b0, 1'b1, inc);
    check("fl_idle", {31'd0, bus.o_valid}, 32'd0);
`else
    repeat (20) begin
      step(1'b0, 1'b1, inc);
      check("nofl_quiet", {31'd0, bus.o_valid}, 32'd0);
    end
`endif

    check("sb_empty", sb_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/fifo_word_packer.md
# fifo_word_packer

Read-side consumer of the clock-domain-crossing FIFO. It drains DATA_WIDTH-bit entries from a show-ahead FIFO read port (`r_empty` / `r_inc` / `r_data`) and packs LANES consecutive entries into one wide word. It presents that word on a registered valid/ready stream for downstream pixel/SRAM logic. Sustained throughput is one FIFO entry per clock.

## Interface
- `DATA_WIDTH`, 8 — width of one FIFO entry (one lane).
- `LANES`, 2 — entries per output word; must be ≥ 2.
- `PACK_TIMEOUT`, 16 — idle cycles before a partial word is flushed; only used with `FIFO_WORD_PACKER_FLUSH_EN`; must be ≥ 1.

Ports:
- `clk`  in  1 — single clock, same domain as the FIFO read side.
- `reset`  in  1 — synchronous, active-high.
- `r_empty`  in  1 — FIFO empty. When low, `r_data` holds the head entry.
- `r_data`  in  DATA_WIDTH — FIFO head entry (show-ahead).
- `r_inc`  out  1 — pop the FIFO head at this rising edge.
- `o_valid`  out  1 — output word valid.
- `o_ready`  in  1 — downstream accepts the word.
- `o_data`  out  DATA_WIDTH*LANES — packed word. Lane 0 (bits [DATA_WIDTH-1:0]) holds the oldest entry.
- `o_keep`  out  LANES — per-lane valid mask.

## Operation
- State:
  - `lane_cnt`: 0..LANES-1, count of lanes filled in the accumulator.
  - `acc`: accumulator, (LANES-1)*DATA_WIDTH bits.
  - Output register: `o_data`, `o_keep`, `o_valid`.
- `out_free` = `!o_valid || o_ready`.
- `r_inc` = `!reset && !r_empty && (lane_cnt < LANES-1 || out_free)`. This is combinational; `r_inc` is never high while `r_empty` is high.
- On a pop with `lane_cnt < LANES-1`:
  - Write `r_data` into lane `lane_cnt` of `acc`.
  - `lane_cnt` increments.
- On a pop with `lane_cnt == LANES-1`:
  - `o_data` ← {`r_data`, `acc`}.
  - `o_keep` ← all ones.
  - `o_valid` ← 1.
  - `lane_cnt` ← 0.
- If `o_valid && o_ready` and no new word loads that cycle, `o_valid` ← 0.
- Accept and load in the same cycle: the new word replaces the old one and `o_valid` stays 1.
- While `o_valid && !o_ready`, `o_data` and `o_keep` hold stable. A pop that does not complete a word may still occur, so the accumulator keeps filling under backpressure.
- Wrap-around: `lane_cnt` returns to 0 after LANES-1 and never exceeds LANES-1.

## Timing
- Reset values: `o_valid`=0, `o_data`=0, `o_keep`=0, `lane_cnt`=0, `acc`=0, flush counter=0. `r_inc`=0 while `reset` is high.
- Reset mid-operation discards any partial accumulator and any pending output word. No FIFO entry is popped during the reset cycle.
- Latency: if the last lane is popped at edge N, `o_valid` is high after edge N. Pop-to-valid latency is 1 clock.
- Throughput: with `o_ready` held high and the FIFO non-empty, `r_inc` stays high every cycle. One word is produced every LANES cycles.
- Backpressure: with `o_ready` low and a word pending, popping continues until `lane_cnt == LANES-1`, then stalls. At most LANES-1 extra entries are buffered.
- `r_empty` going high mid-word: `lane_cnt` holds and no partial word is emitted, except via the flush feature below.

## Configuration
- `FIFO_WORD_PACKER_FLUSH_EN` defined:
  - An idle counter increments each cycle that `lane_cnt > 0` and no pop occurs. It clears on any pop.
  - When the count reaches PACK_TIMEOUT and `out_free` holds:
    - Load `acc` into `o_data`, with unfilled lanes = 0.
    - Load `o_keep` with the low `lane_cnt` bits = 1 and the rest = 0.
    - Set `o_valid` ← 1 and `lane_cnt` ← 0.
  - If `out_free` is low when the count is reached, the flush waits for it.
  - A pop that arrives in the flush cycle takes priority; no flush occurs that cycle.
- `FIFO_WORD_PACKER_FLUSH_EN` undefined:
  - No idle counter exists.
  - Partial words wait indefinitely.
  - `o_keep` is all ones whenever `o_valid` is high.

## Test plan
All scenarios use DATA_WIDTH=8, LANES=2.
- Reset: hold `reset` 3 clocks with the FIFO non-empty -> `r_inc`=0, `o_valid`=0, `o_data`=0x0000, `o_keep`=2'b00.
- Streaming: feed 42,43,44,45 with `o_ready`=1 -> `r_inc` high 4 consecutive cycles; words 0x2B2A then 0x2D2C, each valid one cycle after its second pop; `o_keep`=2'b11.
- Backpressure: feed 1,2,3,4 with `o_ready`=0 -> 0x0201 held stable, 3 popped into the accumulator, `r_inc` low with 4 at head. Raise `o_ready` -> 4 pops, 0x0403 follows on the next cycle.
- Empty gap: feed 0x10, leave the FIFO empty 5 cycles, then feed 0x20 -> no output during the gap, then single word 0x2010.
- Mid-word reset: pop 0x55, assert `reset` 1 clock, feed 0x66,0x77 -> output 0x7766; 0x55 never appears.
- Flush (with `FIFO_WORD_PACKER_FLUSH_EN`, PACK_TIMEOUT=4): pop 0xAB, then the FIFO stays empty -> after 4 idle cycles `o_data`=0x00AB, `o_keep`=2'b01. Without the macro -> no output.
